// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, pooling FSM states and lane vector types.
package cnn_pkg;

    localparam int unsigned LANES      = 32;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_W     = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} pool_state_e;

    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

    function automatic elem_t smax(input elem_t a, input elem_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO for pooled lane vectors; count feeds the reader's credit check.
module pool_out_fifo #(
    parameter int unsigned DW    = 256,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                wdata,
    input  logic                         pop,
    output logic [DW-1:0]                rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/maxpool_reader.sv
// 2x2/stride-2 max-pool sweep over per-lane register files, streamed out over valid/ready.
// Optional fused ReLU on the pooled value when POOL_RELU_EN is defined.
module maxpool_reader
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH  = LANES,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [5:0]                        tile_w,
    input  logic [5:0]                        tile_h,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic [WIDTH-1:0][ADDR_W-1:0]      add_1,
    output logic [WIDTH-1:0][ADDR_W-1:0]      add_2,
    output logic [WIDTH-1:0][ADDR_W-1:0]      add_3,
    output logic [WIDTH-1:0][ADDR_W-1:0]      add_4,
    input  logic [WIDTH-1:0][DATA_WIDTH-1:0]  rd_data1,
    input  logic [WIDTH-1:0][DATA_WIDTH-1:0]  rd_data2,
    input  logic [WIDTH-1:0][DATA_WIDTH-1:0]  rd_data3,
    input  logic [WIDTH-1:0][DATA_WIDTH-1:0]  rd_data4,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0][DATA_WIDTH-1:0]  out_data
);

    localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    pool_state_e state;
    logic [5:0]  tw_q, w_q, h_q, r_q, c_q;
    logic        more_q;
    logic [RD_LAT:0] vld_q;
    logic        mx_vld_q;
    logic [WIDTH-1:0][DATA_WIDTH-1:0] mx_q, mx_next, fifo_rdata;
    logic [CNT_W-1:0] inflight_q, fifo_count;

    logic [5:0]  cur_tw, cur_w, cur_h, cur_r, cur_c;
    logic [11:0] prod, base_full, area;
    logic [ADDR_W-1:0] a1, a2, a3, a4;
    logic        last_col, last_win, geom_bad, start_ok, credit_ok, issue, pop;
    elem_t       lane_max;

    // In IDLE the first window is issued straight from the start inputs.
    always_comb begin
        cur_tw    = (state == IDLE) ? tile_w : tw_q;
        cur_w     = (state == IDLE) ? (tile_w & 6'h3e) : w_q;
        cur_h     = (state == IDLE) ? (tile_h & 6'h3e) : h_q;
        cur_r     = (state == IDLE) ? 6'd0 : r_q;
        cur_c     = (state == IDLE) ? 6'd0 : c_q;
        prod      = cur_r * cur_tw;
        base_full = prod + {6'd0, cur_c};
        a1        = ADDR_W'(base_full);
        a2        = a1 + ADDR_W'(1);
        a3        = ADDR_W'(base_full + {6'd0, cur_tw});
        a4        = a3 + ADDR_W'(1);
        last_col  = (cur_c == cur_w - 6'd2);
        last_win  = last_col && (cur_r == cur_h - 6'd2);
        area      = {6'd0, tile_w} * {6'd0, tile_h};
        geom_bad  = (tile_w < 6'd2) || (tile_h < 6'd2) || (area > 12'(1 << ADDR_W));
        pop       = out_valid && out_ready;
        // A slot popped this cycle may be reused by the window issued this cycle.
        credit_ok = (int'(inflight_q) + int'(fifo_count)) < (int'(FIFO_DEPTH) + int'(pop));
        start_ok  = (state == IDLE) && start && !geom_bad;
        issue     = start_ok || ((state == ISSUE) && more_q && credit_ok);
    end

    always_comb begin
        mx_next  = '0;
        lane_max = '0;
        for (int l = 0; l < int'(WIDTH); l++) begin
            lane_max = smax(smax(elem_t'(rd_data1[l]), elem_t'(rd_data2[l])),
                            smax(elem_t'(rd_data3[l]), elem_t'(rd_data4[l])));
`ifdef POOL_RELU_EN
            if (lane_max < 0) lane_max = '0;
`endif
            mx_next[l] = lane_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            add_1      <= '0;
            add_2      <= '0;
            add_3      <= '0;
            add_4      <= '0;
            tw_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            more_q     <= 1'b0;
            vld_q      <= '0;
            mx_vld_q   <= 1'b0;
            mx_q       <= '0;
            inflight_q <= '0;
        end else begin
            cfg_err <= 1'b0;
            done    <= 1'b0;

            if (issue) begin
                add_1  <= {WIDTH{a1}};
                add_2  <= {WIDTH{a2}};
                add_3  <= {WIDTH{a3}};
                add_4  <= {WIDTH{a4}};
                more_q <= !last_win;
                c_q    <= last_col ? 6'd0 : cur_c + 6'd2;
                r_q    <= last_col ? cur_r + 6'd2 : cur_r;
            end

            vld_q[0] <= issue;
            for (int k = 1; k <= int'(RD_LAT); k++) vld_q[k] <= vld_q[k-1];
            mx_vld_q <= vld_q[RD_LAT];
            if (vld_q[RD_LAT]) mx_q <= mx_next;
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(mx_vld_q);

            unique case (state)
                IDLE: begin
                    if (start && geom_bad) begin
                        cfg_err <= 1'b1;
                    end else if (start_ok) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        tw_q  <= tile_w;
                        w_q   <= tile_w & 6'h3e;
                        h_q   <= tile_h & 6'h3e;
                    end
                end
                ISSUE: begin
                    if (!more_q || (issue && last_win)) state <= DRAIN;
                end
                DRAIN: begin
                    if (inflight_q == '0 && fifo_count == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pool_out_fifo #(
        .DW    (WIDTH * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mx_vld_q),
        .wdata (mx_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_rdata : '0;

endmodule

// File: tb/tb_maxpool_reader.sv
// Directed bench for maxpool_reader with a 1-cycle register-file model per lane.
module tb_maxpool_reader;
    import cnn_pkg::*;

    localparam int unsigned RD_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done, cfg_err, out_valid, out_ready;
    logic [5:0] tile_w, tile_h;
    logic [LANES-1:0][ADDR_W-1:0] add_1, add_2, add_3, add_4;
    logic [LANES-1:0][DATA_WIDTH-1:0] rd_data1, rd_data2, rd_data3, rd_data4;
    lane_vec_t out_data;

    maxpool_reader #(
        .WIDTH  (LANES),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_w    (tile_w),
        .tile_h    (tile_h),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .add_1     (add_1),
        .add_2     (add_2),
        .add_3     (add_3),
        .add_4     (add_4),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_data3  (rd_data3),
        .rd_data4  (rd_data4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    logic [DATA_WIDTH-1:0] mem [LANES][32];

    always @(posedge clk) begin
        for (int l = 0; l < int'(LANES); l++) begin
            rd_data1[l] <= mem[l][add_1[l]];
            rd_data2[l] <= mem[l][add_2[l]];
            rd_data3[l] <= mem[l][add_3[l]];
            rd_data4[l] <= mem[l][add_4[l]];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    lane_vec_t got[$];
    int        addr_seq[$];
    int        done_cnt = 0;
    int        bad_hits = 0;
    logic      rec_addr = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt++;
        if (rec_addr && busy) begin
            if (addr_seq.size() == 0 || int'(add_1[0]) != addr_seq[$])
                addr_seq.push_back(int'(add_1[0]));
            // Column 4 and row 4 of a 5x5 tile must never be read.
            for (int k = 0; k < 4; k++) begin
                int a;
                a = (k == 0) ? int'(add_1[0]) : (k == 1) ? int'(add_2[0]) :
                    (k == 2) ? int'(add_3[0]) : int'(add_4[0]);
                if (a % 5 == 4 || (a >= 20 && a <= 24)) bad_hits++;
            end
        end
    end

    int ready_mode = 0;
    int rcyc = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (rcyc < 8) out_ready = rcyc[0];
            else if (rcyc < 18) out_ready = 1'b0;
            else out_ready = 1'b1;
        end
    end

    task automatic fill_lin();
        for (int l = 0; l < int'(LANES); l++)
            for (int a = 0; a < 32; a++) mem[l][a] = DATA_WIDTH'(a);
    endtask

    task automatic clear_obs();
        got.delete();
        addr_seq.delete();
        done_cnt = 0;
        bad_hits = 0;
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk);
        #1;
        tile_w = 6'(w);
        tile_h = 6'(h);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_done_seen"}, int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_lane0(input string tag, input int exp[$]);
        check_eq({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check_eq($sformatf("%s_v%0d", tag, i), int'($signed(got[i][0])), exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        tile_w = '0;
        tile_h = '0;
        fill_lin();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_cfg_err", int'(cfg_err), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_add_1", int'(add_1[0]), 0);
        check_eq("rst_out_data", int'(out_data[0]), 0);

        // 1: 4x4 linear tile
        clear_obs();
        rec_addr = 1'b1;
        pulse_start(4, 4);
        check_eq("t1_busy", int'(busy), 1);
        repeat (2) @(posedge clk);
        #1 check_eq("t1_not_valid_early", int'(out_valid), 0);
        @(posedge clk);
        #1 check_eq("t1_first_valid", int'(out_valid), 1);
        wait_done("t1");
        rec_addr = 1'b0;
        check_lane0("t1", '{5, 7, 13, 15});
        check_eq("t1_addr_cnt", addr_seq.size(), 4);
        for (int i = 0; i < 4 && i < addr_seq.size(); i++)
            check_eq($sformatf("t1_add1_%0d", i), addr_seq[i], (i / 2) * 8 + (i % 2) * 2);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_busy_after", int'(busy), 0);

        // 2: 5x5 tile, odd column/row ignored
        clear_obs();
        rec_addr = 1'b1;
        pulse_start(5, 5);
        check_eq("t2_add3_first", int'(add_3[0]), 5);
        check_eq("t2_add4_first", int'(add_4[7]), 6);
        wait_done("t2");
        rec_addr = 1'b0;
        check_lane0("t2", '{6, 8, 16, 18});
        check_eq("t2_unaddressed", bad_hits, 0);

        // 3: negative data on lane 3
        clear_obs();
        mem[3][0] = 8'hf8;
        mem[3][1] = 8'hfd;
        mem[3][2] = 8'h80;
        mem[3][3] = 8'hff;
        pulse_start(2, 2);
        wait_done("t3");
        check_lane0("t3", '{3});
        if (got.size() > 0) begin
`ifdef POOL_RELU_EN
            check_eq("t3_lane3", int'($signed(got[0][3])), 0);
`else
            check_eq("t3_lane3", int'($signed(got[0][3])), -1);
`endif
        end else begin
            check_eq("t3_lane3_present", got.size(), 1);
        end
        fill_lin();

        // 4: 4x8 under backpressure
        clear_obs();
        rcyc = 0;
        ready_mode = 1;
        pulse_start(4, 8);
        wait_done("t4");
        ready_mode = 0;
        check_lane0("t4", '{5, 7, 13, 15, 21, 23, 29, 31});
        check_eq("t4_done_cnt", done_cnt, 1);

        // 5: geometry rejects and start while busy
        clear_obs();
        pulse_start(8, 6);
        check_eq("t5_cfg_err_big", int'(cfg_err), 1);
        check_eq("t5_busy_big", int'(busy), 0);
        @(posedge clk);
        #1 check_eq("t5_cfg_err_pulse", int'(cfg_err), 0);
        pulse_start(1, 4);
        check_eq("t5_cfg_err_narrow", int'(cfg_err), 1);
        check_eq("t5_busy_narrow", int'(busy), 0);
        clear_obs();
        pulse_start(4, 4);
        pulse_start(2, 2);
        check_eq("t5_cfg_err_busy", int'(cfg_err), 0);
        wait_done("t5");
        check_lane0("t5", '{5, 7, 13, 15});
        check_eq("t5_done_cnt", done_cnt, 1);

        // 6: reset in the middle of an 8x4 sweep
        clear_obs();
        pulse_start(8, 4);
        n = 0;
        while (add_1[0] != 5'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("t6_reach_win3", int'(add_1[0]), 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_out_valid", int'(out_valid), 0);
        check_eq("t6_busy", int'(busy), 0);
        check_eq("t6_add_1", int'(add_1[0]), 0);
        check_eq("t6_add_4", int'(add_4[9]), 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t6_no_done", done_cnt, 0);
        check_eq("t6_idle_valid", int'(out_valid), 0);
        clear_obs();
        pulse_start(4, 4);
        wait_done("t6_rerun");
        check_lane0("t6_rerun", '{5, 7, 13, 15});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
